// File: rtl/fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader_if
// Description : Bundle of the FIFO-side, downstream-side and status signals
//               of fifo_reader.
//               slave  : view used by fifo_reader (drives rd, m_*, status)
//               master : view used by the FIFO/consumer side
//               Signals: en, nostock, housefull, fifo_dout[DW], m_ready (to
//               reader); rd, m_data[DW], m_valid, rd_count[CNTW],
//               full_hits[8], state[2] (from reader).
// Revision    : 1.0  initial release
// ============================================================================
interface fifo_reader_if #(
    parameter int DW   = 8,
    parameter int CNTW = 16
);
    logic            en;
    logic            nostock;
    logic            housefull;
    logic [DW-1:0]   fifo_dout;
    logic            rd;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic [CNTW-1:0] rd_count;
    logic [7:0]      full_hits;
    logic [1:0]      state;

    modport slave (
        input  en, nostock, housefull, fifo_dout, m_ready,
        output rd, m_data, m_valid, rd_count, full_hits, state
    );

    modport master (
        output en, nostock, housefull, fifo_dout, m_ready,
        input  rd, m_data, m_valid, rd_count, full_hits, state
    );
endinterface
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader
// Description : Drains a show-ahead-less FIFO one byte at a time into a
//               valid/ready downstream port. Each byte walks
//               IDLE -> READ (rd strobe) -> CAPT (data returns) -> HOLD
//               (offered until accepted). Keeps a wrapping count of rd
//               strobes and a saturating count of launches made while the
//               FIFO reported full.
//               Ports: clk, rst (sync, active-low), bus (fifo_reader_if.slave)
// Revision    : 1.0  initial release
// ============================================================================
module fifo_reader #(
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fifo_reader_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [DW-1:0]   r_m_data;
    logic            r_m_valid;
    logic [CNTW-1:0] r_rd_count;
    logic [7:0]      r_full_hits;

    logic [1:0]      w_state_nxt;
    logic            w_avail;
    logic            w_xfer;
    logic            w_enter_read;

    // nostock is only looked at through w_avail, and w_avail is only used
    // in IDLE and on a transfer, so the flag is never consulted in READ/CAPT.
    assign w_avail      = bus.en & ~bus.nostock;
    // m_ready is qualified by m_valid so it is ignored while nothing is offered.
    assign w_xfer       = r_m_valid & bus.m_ready;
    assign w_enter_read = (w_state_nxt == S_READ);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_avail) w_state_nxt = S_READ;
            S_READ: w_state_nxt = S_CAPT;
            S_CAPT: w_state_nxt = S_HOLD;
            S_HOLD: if (w_xfer) w_state_nxt = w_avail ? S_READ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_rd_count  <= '0;
            r_full_hits <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            // The strobe is asserted for the single cycle spent in READ.
            if (r_state == S_READ) begin
                r_rd_count <= r_rd_count + c_CNT_ONE;
            end

            // FIFO data is valid the cycle after rd, i.e. while in CAPT.
            if (r_state == S_CAPT) begin
                r_m_data  <= bus.fifo_dout;
                r_m_valid <= 1'b1;
            end else if (w_xfer) begin
                r_m_valid <= 1'b0;
            end

            // Any launch into READ (from IDLE or straight from a transfer)
            // counts when the FIFO is full; stick at 255.
            if (w_enter_read && bus.housefull && (r_full_hits != 8'hFF)) begin
                r_full_hits <= r_full_hits + 8'd1;
            end
        end
    end

    assign bus.rd        = (r_state == S_READ);
    assign bus.m_data    = r_m_data;
    assign bus.m_valid   = r_m_valid;
    assign bus.rd_count  = r_rd_count;
    assign bus.full_hits = r_full_hits;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_reader
// Description : Self-checking bench for fifo_reader. A FIFO model feeds the
//               reader; loaded bytes that must reach the consumer are queued
//               as expectations and a negedge monitor pops and compares them
//               on every transfer. A second reader with CNTW=4 runs in
//               lockstep on the same inputs to observe count wrap.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_reader;

    logic clk;
    logic rst;

    fifo_reader_if #(.DW(8), .CNTW(16)) bus  ();
    fifo_reader_if #(.DW(8), .CNTW(4))  bus4 ();

    fifo_reader #(.DW(8), .CNTW(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fifo_reader #(.DW(8), .CNTW(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.en        = bus.en;
    assign bus4.nostock   = bus.nostock;
    assign bus4.housefull = bus.housefull;
    assign bus4.fifo_dout = bus.fifo_dout;
    assign bus4.m_ready   = bus.m_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;     // written by stimulus only
    int         rd_ptr = 0;     // written by the model only
    int         cyc    = 0;
    int         rd_times[$];    // posedge index of every rd strobe seen

    assign bus.nostock   = (wr_ptr == rd_ptr);
    assign bus.housefull = ((wr_ptr - rd_ptr) >= 16);

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.rd) begin
            bus.fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr        <= rd_ptr + 1;
            rd_times.push_back(cyc);
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfers happen on the posedge after a negedge where valid&ready hold.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst && bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", {24'd0, bus.m_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", {24'd0, bus.m_data}, {24'd0, e});
                end
            end
            if (bus.rd) begin
                check("underrun_rd", {31'd0, bus.nostock}, 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_out);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!bus.m_valid && k < budget) begin
            tick(1);
            k++;
        end
        check(name, {31'd0, bus.m_valid}, 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        bit done;
        tick(3);
        k = 0;
        done = (bus.state == 2'd0) && bus.nostock && (exp_q.size() == 0);
        while (!done && k < budget) begin
            tick(1);
            k++;
            done = (bus.state == 2'd0) && bus.nostock && (exp_q.size() == 0);
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int  base;
        int  base_cyc;
        bit  stable;

        rst        = 1'b0;
        bus.en     = 1'b0;
        bus.m_ready = 1'b0;
        tick(2);

        // Reset state
        check("rst_state",     {30'd0, bus.state},     32'd0);
        check("rst_rd",        {31'd0, bus.rd},        32'd0);
        check("rst_m_valid",   {31'd0, bus.m_valid},   32'd0);
        check("rst_m_data",    {24'd0, bus.m_data},    32'd0);
        check("rst_rd_count",  {16'd0, bus.rd_count},  32'd0);
        check("rst_full_hits", {24'd0, bus.full_hits}, 32'd0);
        rst = 1'b1;
        tick(1);

        // Three bytes, consumer always ready: rd every 3 cycles
        push(8'h24, 1'b1);
        push(8'h81, 1'b1);
        push(8'h09, 1'b1);
        bus.m_ready = 1'b1;
        base = rd_times.size();
        bus.en = 1'b1;
        wait_idle("burst3_idle", 60);
        check("burst3_rd_pulses", rd_times.size() - base, 32'd3);
        if (rd_times.size() >= base + 3) begin
            check("burst3_spacing_1", rd_times[base+1] - rd_times[base],   32'd3);
            check("burst3_spacing_2", rd_times[base+2] - rd_times[base+1], 32'd3);
        end
        check("burst3_rd_count", {16'd0, bus.rd_count}, 32'd3);
        check("burst3_state",    {30'd0, bus.state},    32'd0);
        bus.en = 1'b0;
        tick(2);

        // Backpressure: byte held 10 cycles, taken on first ready cycle
        bus.m_ready = 1'b0;
        push(8'hA5, 1'b1);
        base = rd_times.size();
        bus.en = 1'b1;
        wait_valid("bp_valid", 10);
        bus.en = 1'b0;   // drop enable with the byte in flight
        stable = 1'b1;
        repeat (10) begin
            tick(1);
            if (!bus.m_valid || bus.m_data !== 8'hA5 || bus.state !== 2'd3) stable = 1'b0;
        end
        check("bp_hold_stable", {31'd0, stable}, 32'd1);
        bus.m_ready = 1'b1;
        tick(1);
        check("bp_valid_cleared", {31'd0, bus.m_valid}, 32'd0);
        check("bp_back_to_idle",  {30'd0, bus.state},   32'd0);
        check("bp_single_rd",     rd_times.size() - base, 32'd1);

        // Enable gating: no reads while en=0, rd on 2nd edge after en rises
        push(8'h3C, 1'b1);
        base = rd_times.size();
        tick(20);
        check("en0_no_rd", rd_times.size() - base, 32'd0);
        check("en0_state", {30'd0, bus.state}, 32'd0);
        base_cyc = cyc;
        bus.en = 1'b1;
        wait_idle("en1_idle", 20);
        check("en1_rd_pulses", rd_times.size() - base, 32'd1);
        if (rd_times.size() > base) begin
            check("en1_rd_latency", rd_times[base] - base_cyc, 32'd2);
        end
        bus.en = 1'b0;
        tick(2);

        // Reset while holding a byte: byte is dropped, counters cleared
        bus.m_ready = 1'b0;
        push(8'h5A, 1'b0);
        bus.en = 1'b1;
        wait_valid("rsthold_valid", 10);
        check("rsthold_in_hold", {30'd0, bus.state}, 32'd3);
        rst = 1'b0;
        tick(1);
        check("rsthold_m_valid",  {31'd0, bus.m_valid},  32'd0);
        check("rsthold_state",    {30'd0, bus.state},    32'd0);
        check("rsthold_rd_count", {16'd0, bus.rd_count}, 32'd0);
        bus.en = 1'b0;
        tick(1);
        rst = 1'b1;
        bus.m_ready = 1'b1;
        base = rd_times.size();
        tick(5);
        check("rsthold_no_rd", rd_times.size() - base, 32'd0);

        // Full FIFO drained: one full-launch, 16 reads, no 17th
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
        base = rd_times.size();
        bus.en = 1'b1;
        wait_idle("full_idle", 200);
        check("full_hits",      {24'd0, bus.full_hits}, 32'd1);
        check("full_rd_count",  {16'd0, bus.rd_count},  32'd16);
        check("full_rd_pulses", rd_times.size() - base, 32'd16);
        tick(5);
        check("full_no_17th",   rd_times.size() - base, 32'd16);
        check("full_nostock",   {31'd0, bus.nostock},   32'd1);

        // 17th read: 16-bit count reaches 17, 4-bit count wraps to 1
        push(8'h77, 1'b1);
        wait_idle("wrap_idle", 20);
        check("wrap_rd_count16", {16'd0, bus.rd_count}, 32'd17);
        check("wrap_rd_count4",  {28'd0, bus4.rd_count}, 32'd1);
        bus.en = 1'b0;
        tick(2);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
